// File: rtl/ifft_twiddle_sequencer.sv
// rtl/ifft_twiddle_sequencer.sv - walks the twiddle ROM stage by stage for an IFFT butterfly
// Issues {stage, k} addresses with a valid/ready handshake that holds the ROM output while stalled.
module ifft_twiddle_sequencer #(
  parameter int GROUPS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] num_stages,
  input  logic       tw_ready,
  output logic [4:0] rom_addr,
  output logic       tw_valid,
  output logic [2:0] tw_stage,
  output logic [1:0] tw_k,
  output logic       busy,
  output logic       done
);

  localparam int GW = $clog2(GROUPS) + 1;
  localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t        state_q, state_d;
  logic [2:0]    nstg_q, nstg_d;
  logic [2:0]    stage_q, stage_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [1:0]    k_q, k_d;
  logic [4:0]    rom_addr_q, rom_addr_d;
  logic          tw_valid_q, tw_valid_d;
  logic [2:0]    tw_stage_q, tw_stage_d;
  logic [1:0]    tw_k_q, tw_k_d;
  logic          issue;
  logic          last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      nstg_q     <= '0;
      stage_q    <= '0;
      grp_q      <= '0;
      k_q        <= '0;
      rom_addr_q <= '0;
      tw_valid_q <= 1'b0;
      tw_stage_q <= '0;
      tw_k_q     <= '0;
    end else begin
      state_q    <= state_d;
      nstg_q     <= nstg_d;
      stage_q    <= stage_d;
      grp_q      <= grp_d;
      k_q        <= k_d;
      rom_addr_q <= rom_addr_d;
      tw_valid_q <= tw_valid_d;
      tw_stage_q <= tw_stage_d;
      tw_k_q     <= tw_k_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nstg_d     = nstg_q;
    stage_d    = stage_q;
    grp_d      = grp_q;
    k_d        = k_q;
    rom_addr_d = rom_addr_q;
    tw_valid_d = tw_valid_q;
    tw_stage_d = tw_stage_q;
    tw_k_d     = tw_k_q;

    // A new address may only replace the presented one once it is consumed or absent.
    issue = (state_q == ISSUE) && (!tw_valid_q || tw_ready);
    last  = (stage_q == nstg_q - 3'd1) && (grp_q == G_LAST) && (k_q == 2'd3);

    case (state_q)
      IDLE: begin
        if (start) begin
          nstg_d  = num_stages;
          stage_d = '0;
          grp_d   = '0;
          k_d     = '0;
          state_d = (num_stages != 3'd0) ? ISSUE : FINISH;
        end
      end
      ISSUE: begin
        if (issue) begin
          rom_addr_d = {stage_q, k_q};
          tw_stage_d = stage_q;
          tw_k_d     = k_q;
          tw_valid_d = 1'b1;
          k_d        = k_q + 2'd1;
          if (k_q == 2'd3) begin
            if (grp_q == G_LAST) begin
              grp_d   = '0;
              stage_d = stage_q + 3'd1;
            end else begin
              grp_d = grp_q + GW'(1);
            end
          end
          if (last) begin
            stage_d = '0;
            grp_d   = '0;
            k_d     = '0;
            state_d = DRAIN;
          end
        end else if (tw_valid_q && tw_ready) begin
          tw_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (tw_valid_q && tw_ready) begin
          tw_valid_d = 1'b0;
          state_d    = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rom_addr = rom_addr_q;
  assign tw_valid = tw_valid_q;
  assign tw_stage = tw_stage_q;
  assign tw_k     = tw_k_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);

endmodule
